cfu_l2_initiator: RTL and testbench

- CFU-L2 initiator: turns host commands into CFU-L2 requests and returns CFU-L2 responses to the host.
- Sits upstream of a CFU-L2 responder or mux (e.g. a mux1 plus mulacc composition). Serves as a CPU-side issue port and as the bench/SoC driver for streaming CFUs.
- Bounds requests in flight, carries a host tag per request, tracks protocol status.

---
 rtl/cfu_pkg.sv | 24 ++
 rtl/cfu_tag_fifo.sv | 61 ++++++
 rtl/cfu_l2_initiator.sv | 182 ++++++++++++++++++
 tb/tb_cfu_l2_initiator.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfu_pkg.sv
// Shared CFU-L2 types: response status codes, function id,
// and the initiator error-counter width with its saturating step.
package cfu_pkg;

    localparam int CFU_STATUS_W = 2;

    typedef enum logic [CFU_STATUS_W-1:0] {
        CFU_OK           = 2'd0,
        CFU_ERROR_CFU    = 2'd1,
        CFU_ERROR_OP     = 2'd2,
        CFU_ERROR_CUSTOM = 2'd3
    } cfu_status_t;

    typedef logic [2:0] cfid_t;

    localparam int CFU_L2_INIT_ERR_W = 16;

    function automatic logic [CFU_L2_INIT_ERR_W-1:0] sat_inc(
        input logic [CFU_L2_INIT_ERR_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/cfu_tag_fifo.sv
// Tag FIFO with arbitrary depth; pointers wrap modulo DEPTH.
// A push and pop together on a full FIFO is accepted.
module cfu_tag_fifo #(
    parameter int W     = 4,
    parameter int DEPTH = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= nxt(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/cfu_l2_initiator.sv
// CFU-L2 initiator: registered request slot, in-order tagged
// response slot, bounded in-flight count and saturating error tally.
module cfu_l2_initiator
    import cfu_pkg::*;
#(
    parameter int N_CFUS     = 2,
    parameter int N_STATES   = 1,
    parameter int FUNC_ID_W  = $bits(cfid_t),
    parameter int INSN_W     = 0,
    parameter int DATA_W     = 32,
    parameter int TAG_W      = 4,
    parameter int MAX_OUT    = 4,
    parameter int CFU_ID_W   = (N_CFUS > 1) ? $clog2(N_CFUS) : 1,
    parameter int STATE_ID_W = (N_STATES > 1) ? $clog2(N_STATES) : 1,
    parameter int INSN_PW    = (INSN_W > 0) ? INSN_W : 1,
    parameter int OUT_W      = $clog2(MAX_OUT) + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clk_en,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [CFU_ID_W-1:0]          cmd_cfu,
    input  logic [STATE_ID_W-1:0]        cmd_state,
    input  logic [FUNC_ID_W-1:0]         cmd_func,
    input  logic [INSN_PW-1:0]           cmd_insn,
    input  logic [DATA_W-1:0]            cmd_data0,
    input  logic [DATA_W-1:0]            cmd_data1,
    input  logic [TAG_W-1:0]             cmd_tag,
    output logic                         req_valid,
    input  logic                         req_ready,
    output logic [CFU_ID_W-1:0]          req_cfu,
    output logic [STATE_ID_W-1:0]        req_state,
    output logic [FUNC_ID_W-1:0]         req_func,
    output logic [INSN_PW-1:0]           req_insn,
    output logic [DATA_W-1:0]            req_data0,
    output logic [DATA_W-1:0]            req_data1,
    input  logic                         resp_valid,
    output logic                         resp_ready,
    input  logic [CFU_STATUS_W-1:0]      resp_status,
    input  logic [DATA_W-1:0]            resp_data,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [TAG_W-1:0]             rsp_tag,
    output logic [CFU_STATUS_W-1:0]      rsp_status,
    output logic [DATA_W-1:0]            rsp_data,
    output logic [OUT_W-1:0]             outstanding,
    output logic [CFU_L2_INIT_ERR_W-1:0] err_count,
    output logic                         idle
);

    localparam int CNT_W = OUT_W + 1;

    logic             credit;
    logic [CNT_W-1:0] inflight;
    logic             cmd_fire;
    logic             req_fire;
    logic             resp_fire;
    logic             host_fire;
    logic             fifo_full;
    logic             fifo_empty;
    logic [TAG_W-1:0] fifo_head;

    // The slot counts against the budget, so an empty slot still
    // needs a free credit before it may take a command.
    assign inflight   = CNT_W'(outstanding) + CNT_W'(req_valid);
    assign credit     = inflight < CNT_W'(MAX_OUT);
    assign cmd_ready  = credit && (!req_valid || req_ready);
    assign resp_ready = !rsp_valid || rsp_ready;

    assign cmd_fire  = clk_en && cmd_valid && cmd_ready;
    assign req_fire  = clk_en && req_valid && req_ready;
    assign resp_fire = clk_en && resp_valid && resp_ready;
    assign host_fire = clk_en && rsp_valid && rsp_ready;

    assign idle = !req_valid && (outstanding == '0) && !rsp_valid;

    cfu_tag_fifo #(
        .W     (TAG_W),
        .DEPTH (MAX_OUT + 1)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_fire),
        .pop   (resp_fire),
        .din   (cmd_tag),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_valid <= 1'b0;
            req_cfu   <= '0;
            req_state <= '0;
            req_func  <= '0;
            req_data0 <= '0;
            req_data1 <= '0;
        end else if (cmd_fire) begin
            req_valid <= 1'b1;
            req_cfu   <= cmd_cfu;
            req_state <= cmd_state;
            req_func  <= cmd_func;
            req_data0 <= cmd_data0;
            req_data1 <= cmd_data1;
        end else if (req_fire) begin
            req_valid <= 1'b0;
        end
    end

    if (INSN_W > 0) begin : g_insn
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                req_insn <= '0;
            end else if (cmd_fire) begin
                req_insn <= cmd_insn;
            end
        end
    end else begin : g_no_insn
        logic unused_insn;
        assign unused_insn = ^cmd_insn;
        assign req_insn    = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_tag    <= '0;
            rsp_status <= '0;
            rsp_data   <= '0;
        end else if (resp_fire) begin
            rsp_valid  <= 1'b1;
            rsp_tag    <= fifo_head;
            rsp_status <= resp_status;
            rsp_data   <= resp_data;
        end else if (host_fire) begin
            rsp_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            case ({req_fire, host_fire})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (resp_fire && (resp_status != CFU_OK)) begin
            err_count <= sat_inc(err_count);
        end
    end

`ifndef SYNTHESIS
    a_resp_without_req: assert property (
        @(posedge clk) disable iff (rst)
        resp_valid |-> !fifo_empty);

    a_out_bound: assert property (
        @(posedge clk) disable iff (rst)
        outstanding <= OUT_W'(MAX_OUT));

    a_req_stable: assert property (
        @(posedge clk) disable iff (rst)
        (req_valid && !req_ready) |=>
        $stable({req_cfu, req_state, req_func,
                 req_insn, req_data0, req_data1}));

    a_fifo_room: assert property (
        @(posedge clk) disable iff (rst)
        cmd_fire |-> (!fifo_full || resp_fire));
`endif

endmodule

// File: tb/tb_cfu_l2_initiator.sv
// Bench for cfu_l2_initiator: table-driven single ops, scoreboarded
// streaming, backpressure, host stall, error saturation, mid-flight reset.
module tb_cfu_l2_initiator;
    import cfu_pkg::*;

    localparam int MAX_OUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [0:0]  cmd_cfu;
    logic [0:0]  cmd_state;
    logic [2:0]  cmd_func;
    logic [0:0]  cmd_insn;
    logic [31:0] cmd_data0;
    logic [31:0] cmd_data1;
    logic [3:0]  cmd_tag;
    logic        req_valid;
    logic        req_ready;
    logic [0:0]  req_cfu;
    logic [0:0]  req_state;
    logic [2:0]  req_func;
    logic [0:0]  req_insn;
    logic [31:0] req_data0;
    logic [31:0] req_data1;
    logic        resp_valid;
    logic        resp_ready;
    logic [1:0]  resp_status;
    logic [31:0] resp_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [3:0]  rsp_tag;
    logic [1:0]  rsp_status;
    logic [31:0] rsp_data;
    logic [2:0]  outstanding;
    logic [15:0] err_count;
    logic        idle;

    always #5 clk = ~clk;

    cfu_l2_initiator dut (
        .clk         (clk),
        .rst         (rst),
        .clk_en      (clk_en),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_cfu     (cmd_cfu),
        .cmd_state   (cmd_state),
        .cmd_func    (cmd_func),
        .cmd_insn    (cmd_insn),
        .cmd_data0   (cmd_data0),
        .cmd_data1   (cmd_data1),
        .cmd_tag     (cmd_tag),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_cfu     (req_cfu),
        .req_state   (req_state),
        .req_func    (req_func),
        .req_insn    (req_insn),
        .req_data0   (req_data0),
        .req_data1   (req_data1),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_status (resp_status),
        .resp_data   (resp_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_tag     (rsp_tag),
        .rsp_status  (rsp_status),
        .rsp_data    (rsp_data),
        .outstanding (outstanding),
        .err_count   (err_count),
        .idle        (idle)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    typedef struct packed {
        logic [3:0]  tag;
        logic [1:0]  st;
        logic [31:0] d;
    } exp_t;

    typedef struct packed {
        logic [0:0]  cfu;
        logic [2:0]  func;
        logic [31:0] d0;
        logic [31:0] d1;
    } rq_t;

    typedef struct {
        int          due;
        logic [1:0]  st;
        logic [31:0] d;
    } rs_t;

    typedef struct {
        logic [0:0]  cfu;
        logic [2:0]  func;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [3:0]  tag;
        logic [1:0]  es;
        logic [31:0] ed;
    } vec_t;

    exp_t sb[$];
    rq_t  rq[$];
    rs_t  rs[$];

    int lat = 1;
    bit bp_mode = 0;
    int max_seen = 0;
    int full_leak = 0;

    function automatic rs_t resp_of(input logic [0:0] cfu,
                                    input logic [31:0] a,
                                    input logic [31:0] b);
        rs_t r;
        r.due = 0;
        if (cfu == 1'b1) begin
            r.st = CFU_ERROR_OP;
            r.d  = 32'd0;
        end else begin
            r.st = CFU_OK;
            r.d  = a * b;
        end
        return r;
    endfunction

    // Responder: in-order, fixed latency, optional 1-in-3 req_ready.
    initial begin
        int  n = 0;
        bit  stalled = 0;
        rq_t saved;
        rq_t cur;
        rq_t r;
        rs_t x;
        req_ready   = 1'b1;
        resp_valid  = 1'b0;
        resp_status = '0;
        resp_data   = '0;
        forever begin
            @(negedge clk);
            n++;
            if (rst) begin
                rs.delete();
                resp_valid = 1'b0;
                stalled    = 0;
            end else begin
                req_ready  = bp_mode ? (n % 3 == 0) : 1'b1;
                resp_valid = (rs.size() > 0) && (rs[0].due <= n);
                if (resp_valid) begin
                    resp_status = rs[0].st;
                    resp_data   = rs[0].d;
                end
                #1;
                cur = '{req_cfu, req_func, req_data0, req_data1};
                if (stalled && req_valid)
                    chk("req_stable", 32'(cur == saved), 1);
                stalled = req_valid && !req_ready;
                if (stalled) saved = cur;
                if (clk_en && resp_valid && resp_ready)
                    void'(rs.pop_front());
                if (clk_en && req_valid && req_ready) begin
                    if (rq.size() == 0) begin
                        chk("req_unexpected", 1, 0);
                    end else begin
                        r = rq.pop_front();
                        chk("req_fields", 32'(cur == r), 1);
                    end
                    x = resp_of(req_cfu, req_data0, req_data1);
                    x.due = n + lat;
                    rs.push_back(x);
                end
            end
        end
    end

    // Host-side scoreboard and flow monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                if (int'(outstanding) > max_seen)
                    max_seen = int'(outstanding);
                if (outstanding == 3'(MAX_OUT) && cmd_ready)
                    full_leak++;
                if (clk_en && rsp_valid && rsp_ready) begin
                    if (sb.size() == 0) begin
                        chk("rsp_unexpected", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
                        chk("rsp_status", 32'(rsp_status), 32'(e.st));
                        chk("rsp_data", rsp_data, e.d);
                    end
                end
            end
        end
    end

    task automatic send(input logic [0:0] cfu, input logic [2:0] func,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [3:0] tag, input logic [1:0] es,
                        input logic [31:0] ed);
        int w = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_cfu   = cfu;
        cmd_func  = func;
        cmd_data0 = d0;
        cmd_data1 = d1;
        cmd_tag   = tag;
        #1;
        while (!(cmd_ready && clk_en)) begin
            @(negedge clk);
            #1;
            w++;
            if (w > 300) begin
                chk("cmd_timeout", 0, 1);
                cmd_valid = 1'b0;
                return;
            end
        end
        sb.push_back('{tag, es, ed});
        rq.push_back('{cfu, func, d0, d1});
    endtask

    task automatic send_m(input logic [0:0] cfu, input logic [2:0] func,
                          input logic [31:0] d0, input logic [31:0] d1,
                          input logic [3:0] tag);
        rs_t m;
        m = resp_of(cfu, d0, d1);
        send(cfu, func, d0, d1, tag, m.st, m.d);
    endtask

    task automatic send_v(input vec_t v);
        send(v.cfu, v.func, v.d0, v.d1, v.tag, v.es, v.ed);
    endtask

    task automatic cmd_off();
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int w = 0;
        cmd_off();
        #2;
        while (!(idle && sb.size() == 0)) begin
            @(negedge clk);
            #2;
            w++;
            if (w > budget) begin
                chk("drain_timeout", 0, 1);
                return;
            end
        end
    endtask

    initial begin
        #300000;
        chk("watchdog", 0, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        vec_t vt[5];
        vt[0] = '{1'b0, 3'd0, 32'd3, 32'd5, 4'd7, CFU_OK, 32'd15};
        vt[1] = '{1'b0, 3'd3, 32'd100, 32'd7, 4'd2, CFU_OK, 32'd700};
        vt[2] = '{1'b0, 3'd1, 32'hFFFF_FFFF, 32'd2, 4'd15,
                  CFU_OK, 32'hFFFF_FFFE};
        vt[3] = '{1'b0, 3'd7, 32'd0, 32'd12345, 4'd0, CFU_OK, 32'd0};
        vt[4] = '{1'b0, 3'd5, 32'h1_0000, 32'h1_0000, 4'd9,
                  CFU_OK, 32'd0};

        rst       = 1'b1;
        clk_en    = 1'b1;
        cmd_valid = 1'b0;
        cmd_cfu   = '0;
        cmd_state = '0;
        cmd_func  = '0;
        cmd_insn  = '0;
        cmd_data0 = '0;
        cmd_data1 = '0;
        cmd_tag   = '0;
        rsp_ready = 1'b1;

        repeat (2) @(negedge clk);
        #2;
        chk("rst_req_valid", 32'(req_valid), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_outstanding", 32'(outstanding), 0);
        chk("rst_err_count", 32'(err_count), 0);
        chk("rst_idle", 32'(idle), 1);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        @(negedge clk);
        #3 rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            send_v(vt[i]);
            wait_idle(60);
            chk("vec_outstanding", 32'(outstanding), 0);
            chk("vec_idle", 32'(idle), 1);
        end

        @(negedge clk);
        clk_en = 1'b0;
        fork
            send_v(vt[1]);
            begin
                repeat (3) @(negedge clk);
                #2;
                chk("clk_en_hold", 32'(req_valid), 0);
                chk("clk_en_ready", 32'(cmd_ready), 1);
                @(negedge clk);
                clk_en = 1'b1;
            end
        join
        wait_idle(60);

        lat       = 3;
        max_seen  = 0;
        full_leak = 0;
        for (int t = 0; t < 8; t++)
            send_m(1'b0, 3'(t), 32'(t + 1), 32'(t + 2), 4'(t));
        wait_idle(200);
        chk("b2b_max_out", 32'(max_seen), MAX_OUT);
        chk("b2b_full_ready", 32'(full_leak), 0);

        lat     = 2;
        bp_mode = 1;
        for (int k = 0; k < 20; k++) begin
            int g;
            send_m(1'b0, 3'($urandom_range(0, 7)), $urandom,
                   $urandom, 4'($urandom_range(0, 15)));
            g = $urandom_range(0, 2);
            if (g > 0) begin
                @(negedge clk);
                cmd_valid = 1'b0;
                repeat (g - 1) @(negedge clk);
            end
        end
        wait_idle(400);
        bp_mode = 0;
        chk("bp_all_issued", 32'(rq.size()), 0);

        lat = 1;
        @(negedge clk);
        rsp_ready = 1'b0;
        fork
            for (int t = 0; t < 6; t++)
                send_m(1'b0, 3'(t), 32'(t), 32'd3, 4'(8 + t));
            begin
                repeat (20) @(negedge clk);
                #2;
                chk("stall_resp_ready", 32'(resp_ready), 0);
                chk("stall_outstanding", 32'(outstanding), MAX_OUT);
                chk("stall_cmd_ready", 32'(cmd_ready), 0);
                chk("stall_rsp_valid", 32'(rsp_valid), 1);
                @(negedge clk);
                rsp_ready = 1'b1;
            end
        join
        wait_idle(200);

        for (int t = 0; t < 3; t++)
            send(1'b1, 3'd2, 32'(t), 32'd9, 4'(t),
                 CFU_ERROR_OP, 32'd0);
        wait_idle(100);
        chk("err_count_3", 32'(err_count), 3);

        @(negedge clk);
        force dut.err_count = 16'hFFFE;
        @(negedge clk);
        release dut.err_count;
        #1;
        chk("err_forced", 32'(err_count), 32'hFFFE);
        for (int t = 0; t < 3; t++)
            send(1'b1, 3'd4, 32'd1, 32'd1, 4'(3 + t),
                 CFU_ERROR_OP, 32'd0);
        wait_idle(100);
        chk("err_saturate", 32'(err_count), 32'hFFFF);

        @(negedge clk);
        rsp_ready = 1'b0;
        for (int t = 1; t <= 3; t++)
            send_m(1'b0, 3'd1, 32'(t), 32'd2, 4'(t));
        cmd_off();
        repeat (5) @(negedge clk);
        #2;
        chk("pre_rst_outstanding", 32'(outstanding), 3);
        #1;
        rst = 1'b1;
        sb.delete();
        rq.delete();
        rs.delete();
        #1;
        chk("mid_rst_req_valid", 32'(req_valid), 0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
        chk("mid_rst_outstanding", 32'(outstanding), 0);
        chk("mid_rst_err_count", 32'(err_count), 0);
        chk("mid_rst_idle", 32'(idle), 1);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        #3 rst = 1'b0;
        send_v(vt[0]);
        wait_idle(60);
        chk("post_rst_idle", 32'(idle), 1);
        chk("post_rst_err", 32'(err_count), 0);
        chk("final_sb_empty", 32'(sb.size()), 0);
        chk("final_rq_empty", 32'(rq.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
